// File: rtl/cmp_pkg.sv
// Shared compare-mode encodings and the mode-to-outcome selection used by cmp_stream.
package cmp_pkg;

  localparam logic [1:0] CMP_GT = 2'b00;
  localparam logic [1:0] CMP_LT = 2'b01;
  localparam logic [1:0] CMP_EQ = 2'b10;
  localparam logic [1:0] CMP_GE = 2'b11;

  function automatic logic sel_result(input logic [1:0] mode, input logic gt, input logic eq,
                                      input logic lt);
    case (mode)
      CMP_GT:  return gt;
      CMP_LT:  return lt;
      CMP_EQ:  return eq;
      default: return gt | eq;
    endcase
  endfunction

endpackage

// File: rtl/cmp_core.sv
// Combinational magnitude compare of two WIDTH-bit operands into gt/eq/lt flags.
// Two's-complement when CMP_SIGNED_EN is defined, unsigned otherwise.
module cmp_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

`ifdef CMP_SIGNED_EN
  assign gt = $signed(a) > $signed(b);
  assign lt = $signed(a) < $signed(b);
`else
  assign gt = a > b;
  assign lt = a < b;
`endif
  assign eq = (a == b);

endmodule

// File: rtl/cmp_stream.sv
// Registered, valid/ready operand comparator with running max of A and saturating true counter.
// Latency 1; CMP_SIGNED_EN selects two's-complement compare and most-negative max_a init.
module cmp_stream
  import cmp_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 result,
  output logic                 gt,
  output logic                 eq,
  output logic                 lt,
  output logic [WIDTH-1:0]     max_a,
  output logic [CNT_WIDTH-1:0] true_cnt,
  input  logic                 clear
);

`ifdef CMP_SIGNED_EN
  localparam logic [WIDTH-1:0] MAX_INIT = {1'b1, {(WIDTH-1){1'b0}}};
`else
  localparam logic [WIDTH-1:0] MAX_INIT = '0;
`endif
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 accept;
  logic                 d_gt, d_eq, d_lt, d_result;
  logic                 m_gt, m_eq, m_lt, max_take;
  logic [WIDTH-1:0]     max_base, max_next;
  logic [CNT_WIDTH-1:0] cnt_base, cnt_next;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  cmp_core #(.WIDTH(WIDTH)) u_cmp_pair (
    .a  (a),
    .b  (b),
    .gt (d_gt),
    .eq (d_eq),
    .lt (d_lt)
  );

  assign d_result = sel_result(mode, d_gt, d_eq, d_lt);

  // Clear takes effect before a coinciding accept, so the compare runs against the cleared base.
  assign max_base = clear ? MAX_INIT : max_a;

  cmp_core #(.WIDTH(WIDTH)) u_cmp_max (
    .a  (a),
    .b  (max_base),
    .gt (m_gt),
    .eq (m_eq),
    .lt (m_lt)
  );

  assign max_take = m_gt & ~m_eq & ~m_lt;
  assign max_next = (accept && max_take) ? a : max_base;

  assign cnt_base = clear ? '0 : true_cnt;
  assign cnt_next = (accept && d_result && (cnt_base != CNT_MAX)) ? cnt_base + CNT_ONE : cnt_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
      max_a     <= MAX_INIT;
      true_cnt  <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        result    <= d_result;
        gt        <= d_gt;
        eq        <= d_eq;
        lt        <= d_lt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      max_a    <= max_next;
      true_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_cmp_stream.sv
// Bench for cmp_stream: directed scenarios plus random traffic against a queue-based reference.
module tb_cmp_stream;

  localparam logic [1:0] M_GT = 2'b00;
  localparam logic [1:0] M_LT = 2'b01;
  localparam logic [1:0] M_EQ = 2'b10;
  localparam logic [1:0] M_GE = 2'b11;
`ifdef CMP_SIGNED_EN
  localparam int MAX_MIN = -128;
`else
  localparam int MAX_MIN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [1:0] mode = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       result, gt, eq, lt;
  logic [7:0] max_a;
  logic [3:0] true_cnt;
  logic       clear = 1'b0;

  int checks = 0;
  int errors = 0;

  cmp_stream #(.WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .gt        (gt),
    .eq        (eq),
    .lt        (lt),
    .max_a     (max_a),
    .true_cnt  (true_cnt),
    .clear     (clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ival(input logic [7:0] v);
`ifdef CMP_SIGNED_EN
    return int'($signed(v));
`else
    return int'(v);
`endif
  endfunction

  // Reference: pending results as a queue of {result,gt,eq,lt}; max/count as plain integers.
  logic [3:0] pend[$];
  int         m_max = 0;
  int         m_cnt = 0;
  bit         armed = 0;

  always @(negedge clk) begin
    int  ai, bi;
    bit  acc, r;
    logic [3:0] ent;
    logic [7:0] mx;
    if (armed) begin
      mx = m_max[7:0];
      check("out_valid", out_valid, pend.size() != 0);
      check("in_ready", in_ready, (pend.size() == 0) || out_ready);
      if (pend.size() != 0) begin
        ent = pend[0];
        check("result", result, ent[3]);
        check("flags", {gt, eq, lt}, ent[2:0]);
      end
      check("max_a", max_a, mx);
      check("true_cnt", true_cnt, m_cnt);
    end
    if (rst) begin
      pend.delete();
      m_max = MAX_MIN;
      m_cnt = 0;
      armed = 1;
    end else begin
      acc = in_valid && ((pend.size() == 0) || out_ready);
      if (pend.size() != 0 && out_ready) void'(pend.pop_front());
      if (clear) begin
        m_max = MAX_MIN;
        m_cnt = 0;
      end
      if (acc) begin
        ai = ival(a);
        bi = ival(b);
        case (mode)
          M_GT:    r = ai > bi;
          M_LT:    r = ai < bi;
          M_EQ:    r = ai == bi;
          default: r = ai >= bi;
        endcase
        pend.push_back({r, ai > bi, ai == bi, ai < bi});
        if (ai > m_max) m_max = ai;
        if (r && m_cnt < 15) m_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [1:0] mv);
    bit took = 0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    mode = mv;
    for (int n = 0; n < 100 && !took; n++) begin
      @(negedge clk);
      took = in_ready;
      step();
    end
    if (!took) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  initial begin : stim
    logic [7:0] ra;
    // 1: reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {gt, eq, lt}, 0);
    check("rst_true_cnt", true_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_max_a", ival(max_a), MAX_MIN);
    step();

    // 2: three GT compares
    out_ready = 1'b1;
    send(8'h00, 8'h0A, M_GT);
    check("t2_r0", result, 0);
    send(8'h0A, 8'h0A, M_GT);
    check("t2_r1", result, 0);
    check("t2_eq1", eq, 1);
    send(8'h0F, 8'h0A, M_GT);
    check("t2_r2", result, 1);
    check("t2_cnt", true_cnt, 1);
    check("t2_max", max_a, 8'h0F);

    // 3: equal operands under every mode
    send(8'd5, 8'd5, M_GT);
    check("t3_gt", result, 0);
    send(8'd5, 8'd5, M_LT);
    check("t3_lt", result, 0);
    send(8'd5, 8'd5, M_EQ);
    check("t3_eq", result, 1);
    send(8'd5, 8'd5, M_GE);
    check("t3_ge", result, 1);
    step();

    // 4: stall then back-to-back drain
    out_ready = 1'b0;
    send(8'h01, 8'h00, M_GT);
    in_valid = 1'b1;
    a = 8'h02;
    b = 8'h03;
    mode = M_LT;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_stall_rdy", in_ready, 0);
      check("t4_hold", result, 1);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_rdy", in_ready, 1);
    step();
    check("t4_v2", out_valid, 1);
    check("t4_r2", result, 1);
    a = 8'h09;
    b = 8'h09;
    mode = M_GT;
    @(negedge clk);
    check("t4_rdy3", in_ready, 1);
    step();
    check("t4_v3", out_valid, 1);
    check("t4_r3", result, 0);
    in_valid = 1'b0;
    step();

    // 5: counter saturation and clear with coincident accept
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 17; i++) send(i[7:0], 8'h00, M_GE);
    check("t5_sat", true_cnt, 4'hF);
    check("t5_max", max_a, 8'd16);
    clear = 1'b1;
    send(8'h03, 8'h01, M_GT);
    clear = 1'b0;
    check("t5_clr_cnt", true_cnt, 1);
    check("t5_clr_max", max_a, 8'h03);

    // 6: signedness
    send(8'h80, 8'h01, M_GT);
`ifdef CMP_SIGNED_EN
    check("t6_80_01", result, 0);
`else
    check("t6_80_01", result, 1);
`endif
    send(8'hFF, 8'hFE, M_GT);
    check("t6_ff_fe", result, 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      ra = 8'($urandom);
      in_valid  = 1'($urandom);
      a         = ra;
      b         = ($urandom_range(3) == 0) ? ra : 8'($urandom);
      mode      = 2'($urandom);
      out_ready = ($urandom_range(3) != 0);
      clear     = ($urandom_range(15) == 0);
      rst       = ($urandom_range(63) == 0);
      step();
    end
    in_valid  = 1'b0;
    clear     = 1'b0;
    rst       = 1'b0;
    out_ready = 1'b1;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
